// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed driver for an N-digit common-anode
// seven-segment display. It shows a captured binary value as hex or as
// unsigned decimal, using a sequential double-dabble converter.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_display #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     value,
    input  logic                  load,
    input  logic                  hex_mode,
    output logic                  busy,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int unsigned CNT_W      = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCD_DIGITS = (DATA_W + 2) / 3;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned SH_W       = $clog2(DATA_W + 1);
    localparam int unsigned DISP_W     = 4 * NUM_DIGITS;
    localparam int unsigned PAD_W      = (DATA_W > DISP_W) ? DATA_W : DISP_W;
    localparam int unsigned DD_W       = BCD_W + DATA_W;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              wrap;
    logic [DISP_W-1:0] digits;
    logic              ovf;
    logic [BCD_W-1:0]  bcd, bcd_adj, bcd_shift;
    logic [DATA_W-1:0] bin, bin_shift;
    logic [DD_W-1:0]   dd_shift;
    logic [SH_W-1:0]   sh_cnt;
    logic              load_ok;
    logic [PAD_W-1:0]  value_pad;
    logic [DISP_W-1:0] hex_digits, dec_digits;
    logic              hex_ovf, dec_ovf;
    logic [3:0]        digit_arr [NUM_DIGITS];
    logic [3:0]        cur_digit;
    logic              blank_cur;
    logic [6:0]        seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Active-low segment pattern for one hex digit (bit 6 = g ... bit 0 = a)
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'h0:    enc = 7'b1000000;
            4'h1:    enc = 7'b1111001;
            4'h2:    enc = 7'b0100100;
            4'h3:    enc = 7'b0110000;
            4'h4:    enc = 7'b0011001;
            4'h5:    enc = 7'b0010010;
            4'h6:    enc = 7'b0000010;
            4'h7:    enc = 7'b1111000;
            4'h8:    enc = 7'b0000000;
            4'h9:    enc = 7'b0010000;
            4'hA:    enc = 7'b0001000;
            4'hB:    enc = 7'b0000011;
            4'hC:    enc = 7'b1000110;
            4'hD:    enc = 7'b0100001;
            4'hE:    enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    assign load_ok = load & ~busy;

    // Hex view: nibbles of the zero-extended value; overflow if bits above the display
    assign value_pad  = PAD_W'(value);
    assign hex_digits = value_pad[DISP_W-1:0];
    assign hex_ovf    = (value_pad >> DISP_W) != '0;

    // Double-dabble step: add 3 to every BCD digit >= 5, then shift left by one
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = (bcd[4*g +: 4] >= 4'd5) ? bcd[4*g +: 4] + 4'd3
                                                             : bcd[4*g +: 4];
    end
    assign dd_shift  = {bcd_adj, bin} << 1;
    assign bcd_shift = dd_shift[DD_W-1:DATA_W];
    assign bin_shift = dd_shift[DATA_W-1:0];

    // Decimal view: low BCD digits to the display, overflow if any higher digit is nonzero
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        if (g < BCD_DIGITS) begin : g_bcd
            assign dec_digits[4*g +: 4] = bcd[4*g +: 4];
        end else begin : g_zero
            assign dec_digits[4*g +: 4] = 4'd0;
        end
    end
    if (BCD_DIGITS > NUM_DIGITS) begin : g_dec_ovf
        assign dec_ovf = |bcd[BCD_W-1:DISP_W];
    end else begin : g_no_dec_ovf
        assign dec_ovf = 1'b0;
    end

    // Converter next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_ok && !hex_mode) state_next = CONVERT;
            CONVERT: if (sh_cnt == SH_W'(DATA_W - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Converter state register and registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Load capture, shift iterations and digit register write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd    <= '0;
            bin    <= '0;
            sh_cnt <= '0;
            digits <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        if (hex_mode) begin
                            digits <= hex_digits;
                            ovf    <= hex_ovf;
                        end else begin
                            bin    <= value;
                            bcd    <= '0;
                            sh_cnt <= '0;
                        end
                    end
                end
                CONVERT: begin
                    bcd    <= bcd_shift;
                    bin    <= bin_shift;
                    sh_cnt <= sh_cnt + SH_W'(1);
                end
                DONE: begin
                    digits <= dec_digits;
                    ovf    <= dec_ovf;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_arr
        assign digit_arr[g] = digits[4*g +: 4];
    end

    // Refresh counter and digit index for the next scan slot
    assign wrap     = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);
    assign idx_next = !wrap ? idx :
                      (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

    assign cur_digit = digit_arr[idx_next];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:0]   nz_from;
    logic [NUM_DIGITS-1:0] blank_vec;
    assign nz_from[NUM_DIGITS] = 1'b0;
    // A digit is blank when it and every digit above it are zero; digit 0 always shows
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_blank
        assign nz_from[g] = nz_from[g+1] | (digit_arr[g] != 4'd0);
        if (g == 0) begin : g_first
            assign blank_vec[g] = 1'b0;
        end else begin : g_upper
            assign blank_vec[g] = ~nz_from[g];
        end
    end
    assign blank_cur = blank_vec[idx_next];
`else
    assign blank_cur = 1'b0;
`endif

    // Segment pattern for the upcoming slot; overflow dashes take priority over blanking
    always_comb begin
        seg_next = enc(cur_digit);
        if (blank_cur) seg_next = SEG_BLANK;
        if (ovf)       seg_next = SEG_DASH;
    end

    assign an_next = ~(NUM_DIGITS'(1) << idx_next);

    // Scan registers: counter, index and the registered display pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
